// File: rtl/reg_load_pkg.sv
// Shared types and helpers for the register-load scheduler: FSM encoding,
// default widths and a one-hot decoder.
package reg_load_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    typedef enum logic {
        ARB  = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Indices of 16 or more decode to all zeros, so oversized addresses select nothing.
    function automatic logic [15:0] onehot16(input logic [4:0] sel);
        logic [15:0] v;
        v = '0;
        if (sel < 5'd16) begin
            v[sel[3:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] cand;

    // Scan from the far end so that the nearest candidate to ptr is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_load_scheduler.sv
// Round-robin scheduler sharing one register bank between NREQ requesters.
// Optional write protection is enabled by defining RLS_PROTECT_EN.
module reg_load_scheduler
    import reg_load_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef RLS_PROTECT_EN
    input  logic [NREG-1:0]      protect,
    output logic                 err,
`endif
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREG-1:0]      load_en,
    output logic [DW-1:0]        load_data,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] arb_idx;
    logic          arb_vld;

    logic [IW-1:0] idx_p0;
    logic [AW-1:0] addr_p0;
    logic [DW-1:0] data_p0;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .idx   (arb_idx),
        .valid (arb_vld)
    );

    // ARB -> LOAD capture; request data is held in unreset registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARB;
            ptr   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (arb_vld) begin
                        state   <= LOAD;
                        idx_p0  <= arb_idx;
                        addr_p0 <= req_addr[int'(arb_idx)*AW +: AW];
                        data_p0 <= req_data[int'(arb_idx)*DW +: DW];
                    end
                end
                default: begin
                    state <= ARB;
                    ptr   <= IW'((int'(idx_p0) + 1) % NREQ);
                end
            endcase
        end
    end

    // LOAD outputs: reset masks them in the same cycle so an interrupted write never lands.
    logic [15:0] gnt_dec;
    logic [15:0] en_dec;
    logic        active;
    logic        blocked;
    logic        wr_ok;
    logic        unused_dec;

    assign gnt_dec    = onehot16(5'(idx_p0));
    assign en_dec     = onehot16(5'(addr_p0));
    assign unused_dec = ^{gnt_dec, en_dec};
    assign active     = (state == LOAD) && !reset;

`ifdef RLS_PROTECT_EN
    assign blocked = |(en_dec[NREG-1:0] & protect);
    assign err     = active && blocked;
`else
    assign blocked = 1'b0;
`endif

    assign wr_ok     = active && !blocked;
    assign gnt       = active ? gnt_dec[NREQ-1:0] : '0;
    assign load_en   = wr_ok ? en_dec[NREG-1:0] : '0;
    assign load_data = (|load_en) ? data_p0 : '0;
    assign busy      = active;

endmodule

// File: tb/tb_reg_load_scheduler.sv
// Scoreboard bench for reg_load_scheduler: a transaction-level model predicts
// every grant/write; a negedge monitor compares the DUT outputs each cycle.
module tb_reg_load_scheduler;

    localparam int NREQ = 4;
    localparam int NREG = 6;
    localparam int DW   = 16;
    localparam int AW   = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREG-1:0]    load_en;
    logic [DW-1:0]      load_data;
    logic               busy;
`ifdef RLS_PROTECT_EN
    logic [NREG-1:0]    protect = 6'h01;
    logic               err;
`endif

    reg_load_scheduler #(
        .NREQ (NREQ),
        .NREG (NREG),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef RLS_PROTECT_EN
        .protect   (protect),
        .err       (err),
`endif
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .load_en   (load_en),
        .load_data (load_data),
        .busy      (busy)
    );

    // Requester state
    bit            pend  [NREQ];
    logic [AW-1:0] raddr [NREQ];
    logic [DW-1:0] rdata [NREQ];
    logic [NREQ-1:0] gnt_seen = '0;
    int            rate = 0;

    always_comb begin
        req      = '0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]               = pend[i];
            req_addr[i*AW +: AW] = raddr[i];
            req_data[i*DW +: DW] = rdata[i];
        end
    end

    typedef struct packed {
        int              cyc;
        logic [NREQ-1:0] g;
        logic [NREG-1:0] en;
        logic [DW-1:0]   d;
        logic            e;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          mptr = 0;
    bit          marb = 1'b1;
    int          errors = 0;
    int          checks = 0;
    logic [DW-1:0] model_reg [NREG];
    logic [DW-1:0] bank      [NREG];

    initial begin
        for (int r = 0; r < NREG; r++) begin
            model_reg[r] = '0;
            bank[r]      = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b0;
            raddr[i] = '0;
            rdata[i] = '0;
        end
    end

    // Reference model: a free slot follows every write slot; grant goes to the
    // first pending requester at or after the pointer, pointer moves past it.
    always @(posedge clock) begin
        exp_t e;
        int   w;
        int   a;
        bit   blk;
        cyc = cyc + 1;
        if (reset) begin
            mptr = 0;
            marb = 1'b1;
        end else if (!marb) begin
            marb = 1'b1;
        end else if (|req) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
            end
            a   = int'(raddr[w]);
            blk = 1'b0;
`ifdef RLS_PROTECT_EN
            if (a < NREG) blk = protect[a];
`endif
            e     = '0;
            e.cyc = cyc;
            e.g   = NREQ'(1) << w;
            e.en  = (a < NREG && !blk) ? (NREG'(1) << a) : '0;
            e.d   = (e.en != '0) ? rdata[w] : '0;
            e.e   = blk;
            q.push_back(e);
            mptr = (w + 1) % NREQ;
            marb = 1'b0;
        end
    end

    // Register bank fed by the DUT outputs
    always @(posedge clock) begin
        for (int r = 0; r < NREG; r++) begin
            if (load_en[r]) bank[r] = load_data;
        end
    end

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        bit   have;
        bit   bad;
        e    = '0;
        have = 1'b0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e    = q.pop_front();
            have = !reset;
            if (!have) e = '0;
        end
        if (have) begin
            for (int r = 0; r < NREG; r++) begin
                if (e.en[r]) model_reg[r] = e.d;
            end
        end
        bad = (gnt !== e.g) || (load_en !== e.en) || (load_data !== e.d) || (busy !== have);
`ifdef RLS_PROTECT_EN
        bad = bad || (err !== e.e);
`endif
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL out cyc=%0d got gnt=%b load_en=%b data=%h busy=%b, want gnt=%b load_en=%b data=%h busy=%b",
                     cyc, gnt, load_en, load_data, busy, e.g, e.en, e.d, have);
        end
        gnt_seen = gnt;
    end

    // Requester driver: drop after grant, optionally issue a fresh write
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_seen[i]) pend[i] = 1'b0;
            if (rate > 0 && !pend[i] && $urandom_range(0, 99) < rate) begin
                pend[i]  = 1'b1;
                raddr[i] = AW'($urandom_range(0, 7));
                rdata[i] = DW'($urandom);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic issue(input int i, input int a, input logic [DW-1:0] d);
        pend[i]  = 1'b1;
        raddr[i] = AW'(a);
        rdata[i] = d;
    endtask

    task automatic wait_idle();
        bit idle;
        for (int n = 0; n < 300; n++) begin
            idle = (q.size() == 0);
            for (int i = 0; i < NREQ; i++) if (pend[i]) idle = 1'b0;
            if (idle) begin
                step(2);
                return;
            end
            step(1);
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout got pending=%0d want 0", q.size());
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);

        // Reset lands in the LOAD cycle of a captured write
        issue(0, 2, 16'hBEEF);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wait_idle();

        // Single request
        issue(1, 5, 16'h1234);
        wait_idle();

        // All requesters continuously busy
        rate = 100;
        step(40);
        rate = 0;
        wait_idle();

        // Same address from two requesters, pointer freshly reset
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        issue(0, 3, 16'hAAAA);
        issue(2, 3, 16'h5555);
        wait_idle();
        checks++;
        if (bank[3] !== 16'h5555) begin
            errors++;
            $display("FAIL same_addr got %h want 5555", bank[3]);
        end

        // Out-of-range addresses
        issue(3, 7, 16'hCAFE);
        issue(2, 6, 16'hF00D);
        wait_idle();

        // Protected register then a neighbour
        issue(1, 0, 16'h0BAD);
        wait_idle();
        issue(1, 1, 16'h600D);
        wait_idle();

        // Random traffic
        rate = 30;
        step(1500);
        rate = 0;
        wait_idle();

        for (int r = 0; r < NREG; r++) begin
            checks++;
            if (bank[r] !== model_reg[r]) begin
                errors++;
                $display("FAIL bank[%0d] got %h want %h", r, bank[r], model_reg[r]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
